// File: rtl/imm_gen_stage_if.sv
// Valid/ready bus around the immediate-generation stage.
// Upstream side: in_valid/in_ready/in_instr/in_immsrc.
// Downstream side: out_valid/out_ready/out_imm/out_type/out_illegal.
interface imm_gen_stage_if #(
    parameter int unsigned XLEN = 32
) ();
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [2:0]      in_immsrc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_type;
    logic            out_illegal;

    // The stage itself
    modport slave (
        input  in_valid, in_instr, in_immsrc, out_ready,
        output in_ready, out_valid, out_imm, out_type, out_illegal
    );

    // Whoever drives words in and consumes results
    modport master (
        output in_valid, in_instr, in_immsrc, out_ready,
        input  in_ready, out_valid, out_imm, out_type, out_illegal
    );
endinterface

// File: rtl/imm_gen_stage.sv
// Registered RISC-V immediate generator with a 2-entry skid buffer.
// Type comes from the opcode (AUTO_DECODE=1) or from in_immsrc (AUTO_DECODE=0).
// Optional macro IMM_ZICSR_EN enables type 101 (CSR uimm, zero-extended rs1 field).
module imm_gen_stage #(
    parameter int unsigned XLEN        = 32,
    parameter bit          AUTO_DECODE = 1'b1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    imm_gen_stage_if.slave  bus
);
    localparam int unsigned TW = 3;

    localparam logic [TW-1:0] T_I = 3'b000;
    localparam logic [TW-1:0] T_S = 3'b001;
    localparam logic [TW-1:0] T_B = 3'b010;
    localparam logic [TW-1:0] T_J = 3'b011;
    localparam logic [TW-1:0] T_U = 3'b100;
`ifdef IMM_ZICSR_EN
    localparam logic [TW-1:0] T_Z = 3'b101;
`endif
    localparam logic [TW-1:0] T_X = 3'b111;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [TW-1:0]   typ;
        logic            illegal;
    } entry_t;

    logic [31:0]   instr;
    logic [6:0]    opcode;
    logic [TW-1:0] typ_c;
    logic [31:0]   raw_c;
    logic          illegal_c;
    entry_t        new_c;

    entry_t        slot0;
    entry_t        slot1;
    logic [1:0]    count;
    logic [1:0]    count_nxt_c;
    logic          rdy;
    logic          vld;
    logic          push_c;
    logic          pop_c;

    assign instr  = bus.in_instr;
    assign opcode = instr[6:0];

    // Resolve the immediate type and build the extended immediate for the incoming word
    always_comb begin
        typ_c     = T_X;
        raw_c     = '0;
        illegal_c = 1'b0;
        if (AUTO_DECODE) begin
            case (opcode)
                7'b0000011, 7'b0010011, 7'b1100111: typ_c = T_I;
                7'b1110011: begin
`ifdef IMM_ZICSR_EN
                    typ_c = instr[14] ? T_Z : T_I;
`else
                    typ_c = T_I;
`endif
                end
                7'b0100011:             typ_c = T_S;
                7'b1100011:             typ_c = T_B;
                7'b1101111:             typ_c = T_J;
                7'b0110111, 7'b0010111: typ_c = T_U;
                default:                typ_c = T_X;
            endcase
        end else begin
            typ_c = bus.in_immsrc;
        end
        case (typ_c)
            T_I: raw_c = {{20{instr[31]}}, instr[31:20]};
            T_S: raw_c = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            T_B: raw_c = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            T_J: raw_c = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            T_U: raw_c = {instr[31:12], 12'b0};
`ifdef IMM_ZICSR_EN
            T_Z: raw_c = {27'b0, instr[19:15]};
`endif
            default: begin
                raw_c     = '0;
                illegal_c = 1'b1;
            end
        endcase
        new_c.imm     = XLEN'($signed(raw_c));
        new_c.typ     = typ_c;
        new_c.illegal = illegal_c;
    end

    // Handshake qualifiers and next occupancy
    always_comb begin
        push_c      = bus.in_valid & rdy;
        pop_c       = vld & bus.out_ready;
        count_nxt_c = 2'(count + {1'b0, push_c} - {1'b0, pop_c});
    end

    // Two-slot FIFO; slot0 is the head and drives out_* directly
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot0 <= '0;
            slot1 <= '0;
            count <= 2'd0;
            rdy   <= 1'b1;
            vld   <= 1'b0;
        end else if (flush) begin
            count <= 2'd0;
            rdy   <= 1'b1;
            vld   <= 1'b0;
        end else begin
            count <= count_nxt_c;
            rdy   <= (count_nxt_c != 2'd2);
            vld   <= (count_nxt_c != 2'd0);
            case ({push_c, pop_c})
                2'b10: begin
                    if (count == 2'd0) slot0 <= new_c;
                    else               slot1 <= new_c;
                end
                2'b01: slot0 <= slot1;
                2'b11: begin
                    if (count == 2'd2) begin
                        slot0 <= slot1;
                        slot1 <= new_c;
                    end else begin
                        slot0 <= new_c;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready    = rdy;
    assign bus.out_valid   = vld;
    assign bus.out_imm     = slot0.imm;
    assign bus.out_type    = slot0.typ;
    assign bus.out_illegal = slot0.illegal;
endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: three instances share stimulus
//  da: XLEN=32 auto decode, db: XLEN=64 auto decode, dc: XLEN=32 immsrc-driven.
// Honours IMM_ZICSR_EN the same way the RTL does.
module tb_imm_gen_stage;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [2:0]  in_immsrc;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imm_gen_stage_if #(.XLEN(32)) ia ();
    imm_gen_stage_if #(.XLEN(64)) ib ();
    imm_gen_stage_if #(.XLEN(32)) ic ();

    assign ia.in_valid = in_valid;  assign ia.in_instr = in_instr;
    assign ia.in_immsrc = in_immsrc; assign ia.out_ready = out_ready;
    assign ib.in_valid = in_valid;  assign ib.in_instr = in_instr;
    assign ib.in_immsrc = in_immsrc; assign ib.out_ready = out_ready;
    assign ic.in_valid = in_valid;  assign ic.in_instr = in_instr;
    assign ic.in_immsrc = in_immsrc; assign ic.out_ready = out_ready;

    imm_gen_stage #(.XLEN(32), .AUTO_DECODE(1'b1)) da (.clk(clk), .reset_n(reset_n), .flush(flush), .bus(ia));
    imm_gen_stage #(.XLEN(64), .AUTO_DECODE(1'b1)) db (.clk(clk), .reset_n(reset_n), .flush(flush), .bus(ib));
    imm_gen_stage #(.XLEN(32), .AUTO_DECODE(1'b0)) dc (.clk(clk), .reset_n(reset_n), .flush(flush), .bus(ic));

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [2:0]  immsrc;
        logic [31:0] a_imm;   // auto-decode result (64-bit = sign extension of this)
        logic [2:0]  a_type;
        logic        a_ill;
        logic [31:0] c_imm;   // immsrc-driven result
        logic [2:0]  c_type;
        logic        c_ill;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " a.out_valid"}, 64'(ia.out_valid), 64'd0);
        check({tag, " a.in_ready"},  64'(ia.in_ready),  64'd1);
        check({tag, " b.out_valid"}, 64'(ib.out_valid), 64'd0);
        check({tag, " c.in_ready"},  64'(ic.in_ready),  64'd1);
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{"addi -1",   32'hFFF00093, 3'b000, 32'hFFFFFFFF, 3'b000, 1'b0, 32'hFFFFFFFF, 3'b000, 1'b0};
        vecs[1] = '{"beq -4",    32'hFE000EE3, 3'b010, 32'hFFFFFFFC, 3'b010, 1'b0, 32'hFFFFFFFC, 3'b010, 1'b0};
        vecs[2] = '{"lui",       32'h800000B7, 3'b100, 32'h80000000, 3'b100, 1'b0, 32'h80000000, 3'b100, 1'b0};
`ifdef IMM_ZICSR_EN
        vecs[3] = '{"csrrwi",    32'h3002D0F3, 3'b101, 32'h00000005, 3'b101, 1'b0, 32'h00000005, 3'b101, 1'b0};
`else
        vecs[3] = '{"csrrwi",    32'h3002D0F3, 3'b101, 32'h00000300, 3'b000, 1'b0, 32'h00000000, 3'b101, 1'b1};
`endif
        vecs[4] = '{"add/src110",32'h00000033, 3'b110, 32'h00000000, 3'b111, 1'b1, 32'h00000000, 3'b110, 1'b1};
        vecs[5] = '{"sw -4",     32'hFE112E23, 3'b001, 32'hFFFFFFFC, 3'b001, 1'b0, 32'hFFFFFFFC, 3'b001, 1'b0};
        vecs[6] = '{"jal +8",    32'h0080006F, 3'b011, 32'h00000008, 3'b011, 1'b0, 32'h00000008, 3'b011, 1'b0};
        vecs[7] = '{"addi 2047", 32'h7FF00093, 3'b111, 32'h000007FF, 3'b000, 1'b0, 32'h00000000, 3'b111, 1'b1};

        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
        in_instr = '0; in_immsrc = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_idle("reset");
        check("reset a.out_imm", 64'(ia.out_imm), 64'd0);
        check("reset b.out_type", 64'(ib.out_type), 64'd0);
        check("reset c.out_illegal", 64'(ic.out_illegal), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Back-to-back vectors: each result is checked one cycle after its accept
        for (int i = 0; i <= 8; i++) begin
            if (i > 0) begin
                vec_t v;
                v = vecs[i-1];
                check({v.name, " a.valid"}, 64'(ia.out_valid), 64'd1);
                check({v.name, " a.imm"},   64'(ia.out_imm),   64'(v.a_imm));
                check({v.name, " a.type"},  64'(ia.out_type),  64'(v.a_type));
                check({v.name, " a.ill"},   64'(ia.out_illegal), 64'(v.a_ill));
                check({v.name, " b.imm"},   64'(ib.out_imm),   {{32{v.a_imm[31]}}, v.a_imm});
                check({v.name, " c.imm"},   64'(ic.out_imm),   64'(v.c_imm));
                check({v.name, " c.type"},  64'(ic.out_type),  64'(v.c_type));
                check({v.name, " c.ill"},   64'(ic.out_illegal), 64'(v.c_ill));
            end
            if (i < 8) begin
                check("table in_ready", 64'(ia.in_ready), 64'd1);
                in_valid  = 1'b1;
                in_instr  = vecs[i].instr;
                in_immsrc = vecs[i].immsrc;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        check("drained out_valid", 64'(ia.out_valid), 64'd0);

        // Backpressure: three words offered, only two fit
        out_ready = 1'b0;
        in_valid = 1'b1; in_immsrc = 3'b000; in_instr = 32'h00100093;
        @(negedge clk);
        check("bp in_ready after 1", 64'(ia.in_ready), 64'd1);
        in_instr = 32'h00200093;
        @(negedge clk);
        check("bp in_ready after 2", 64'(ia.in_ready), 64'd0);
        check("bp head imm", 64'(ia.out_imm), 64'd1);
        in_instr = 32'h00300093;
        @(negedge clk);
        check("bp in_ready held", 64'(ia.in_ready), 64'd0);
        check("bp head stable", 64'(ia.out_imm), 64'd1);
        check("bp c head stable", 64'(ic.out_imm), 64'd1);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp drain w2 imm", 64'(ia.out_imm), 64'd2);
        check("bp in_ready reopened", 64'(ia.in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp drain w3 valid", 64'(ia.out_valid), 64'd1);
        check("bp drain w3 imm", 64'(ia.out_imm), 64'd3);
        @(negedge clk);
        check("bp empty", 64'(ia.out_valid), 64'd0);

        // Flush with two entries buffered and a word offered
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00500093;
        repeat (2) @(negedge clk);
        check("flush pre in_ready", 64'(ia.in_ready), 64'd0);
        flush = 1'b1; in_instr = 32'h00600093;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        check_idle("flush full");
        @(negedge clk);
        check("flush stays empty", 64'(ia.out_valid), 64'd0);

        // Flush while a word is actually accepted: the word is dropped
        in_valid = 1'b1; flush = 1'b1; in_instr = 32'h00700093;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        check_idle("flush accept");

        // Async reset mid-stream clears outputs without waiting for a clock
        in_valid = 1'b1; in_instr = 32'hFFF00093;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        check("pre-reset valid", 64'(ia.out_valid), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check_idle("async reset");
        check("async reset a.imm", 64'(ia.out_imm), 64'd0);
        check("async reset b.imm", 64'(ib.out_imm), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("post-reset empty", 64'(ia.out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
